// File: rtl/wisc_pkg.sv
// Shared fetch-stage types: FSM states, HLT opcode, instruction field positions, IF/ID bundle.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package wisc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam logic [3:0] OP_HLT = 4'hF;

  // Low bit of each instruction field
  localparam int OPC_LSB    = 12;
  localparam int COND_LSB   = 8;
  localparam int RS_LSB     = 4;
  localparam int RT_LSB     = 0;
  localparam int IMM4_LSB   = 0;
  localparam int LS_REG_LSB = 8;
  localparam int LS_IMM_LSB = 0;
  localparam int CALL_LSB   = 0;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  imm4;
    logic [3:0]  ls_reg;
    logic [7:0]  ls_imm;
    logic [11:0] call_tgt;
  } if_id_t;

  // Split one instruction word into the IF/ID field bundle (marked valid)
  function automatic if_id_t split_inst(input logic [15:0] inst, input logic [15:0] pc_next);
    if_id_t f;
    f.valid    = 1'b1;
    f.pc       = pc_next;
    f.opcode   = inst[OPC_LSB +: 4];
    f.cond     = inst[COND_LSB +: 4];
    f.rs       = inst[RS_LSB +: 4];
    f.rt       = inst[RT_LSB +: 4];
    f.imm4     = inst[IMM4_LSB +: 4];
    f.ls_reg   = inst[LS_REG_LSB +: 4];
    f.ls_imm   = inst[LS_IMM_LSB +: 8];
    f.call_tgt = inst[CALL_LSB +: 12];
    return f;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Latency: n/a (wires only).
// Backpressure: imem_ready is a single-cycle strobe; req/addr hold until it arrives.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_unit_skid.sv
// Single-entry holding register for one returned word while decode stalls.
// Latency: data visible the cycle after load; full flag registered.
// Backpressure: no overflow check -- caller must not load while full.
module fetch_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic [W-1:0] dat_i,
  output logic         full_o,
  output logic [W-1:0] dat_o
);

  logic         full_q, full_d;
  logic [W-1:0] dat_q, dat_d;

  // Clear beats load beats drain
  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    if (clr_i) begin
      full_d = 1'b0;
    end else if (load_i) begin
      full_d = 1'b1;
      dat_d  = dat_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      dat_q  <= dat_d;
    end
  end

  assign full_o = full_q;
  assign dat_o  = dat_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns PC, requests words from imem, presents IF/ID fields to decode.
// Latency: word accepted in cycle N appears in IF/ID in cycle N+1; 1 instr/cycle on zero-wait memory.
// Backpressure: stall holds IF/ID; one returned word parks in the skid buffer and requests pause.
module if_fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = OP_HLT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [15:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic                   if_id_valid,
  output logic [3:0]             cntrl_opcode,
  output logic [3:0]             branch_cond,
  output logic [3:0]             reg_rs,
  output logic [3:0]             reg_rt_arith,
  output logic [3:0]             arith_imm,
  output logic [3:0]             load_save_reg,
  output logic [7:0]             load_save_imm,
  output logic [11:0]            call_target,
  output logic [15:0]            pc_out,
  output logic                   halted
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  drain_addr_q, drain_addr_d;
  if_id_t       if_id_q, if_id_d;
  logic         halted_q, halted_d;

  logic [15:0]  pc_inc;
  logic         accept;
  logic         acc_hlt;
  logic         skid_full;
  logic         skid_load;
  logic         skid_drain;
  logic [31:0]  skid_dat;

  assign pc_inc     = pc_q + 16'd1;
  // A word counts only in REQ; a redirect in the same cycle drops it
  assign accept     = (state_q == REQ) && imem.imem_ready && !redirect_valid;
  assign acc_hlt    = accept && (imem.imem_rdata[OPC_LSB +: 4] == HLT_OPCODE);
  assign skid_load  = accept && stall;
  assign skid_drain = !redirect_valid && !stall && skid_full;

  fetch_skid_buf #(.W(32)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect_valid),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .dat_i   ({imem.imem_rdata, pc_inc}),
    .full_o  (skid_full),
    .dat_o   (skid_dat)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = REQ;
      REQ: begin
        if (redirect_valid)         state_d = imem.imem_ready ? REQ : DRAIN;
        else if (acc_hlt)           state_d = HALT;
        else if (accept && stall)   state_d = HOLD;
      end
      HOLD:  if (redirect_valid || !stall) state_d = REQ;
      DRAIN: if (imem.imem_ready)          state_d = REQ;
      HALT:  if (redirect_valid)           state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request only in REQ, or DRAIN where the abandoned address must stay put
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = 16'h0000;
    unique case (state_q)
      REQ: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc_q;
      end
      DRAIN: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = drain_addr_q;
      end
      default: ;
    endcase
  end

  // PC and the in-flight address kept for draining after a redirect
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      if (state_q == REQ && !imem.imem_ready) drain_addr_d = pc_q;
    end else if (accept) begin
      pc_d = pc_inc;
    end
  end

  // IF/ID update: redirect, then stall, then skid, then fresh word, else bubble
  always_comb begin
    if_id_d  = if_id_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      if_id_d.valid = 1'b0;
      halted_d      = 1'b0;
    end else if (!stall) begin
      if (skid_full) begin
        if_id_d = split_inst(skid_dat[31:16], skid_dat[15:0]);
        if (skid_dat[16 + OPC_LSB +: 4] == HLT_OPCODE) halted_d = 1'b1;
      end else if (accept) begin
        if_id_d = split_inst(imem.imem_rdata, pc_inc);
        if (acc_hlt) halted_d = 1'b1;
      end else begin
        if_id_d.valid = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= 16'h0000;
      if_id_q      <= '0;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      if_id_q      <= if_id_d;
      halted_q     <= halted_d;
    end
  end

  assign if_id_valid   = if_id_q.valid;
  assign cntrl_opcode  = if_id_q.opcode;
  assign branch_cond   = if_id_q.cond;
  assign reg_rs        = if_id_q.rs;
  assign reg_rt_arith  = if_id_q.rt;
  assign arith_imm     = if_id_q.imm4;
  assign load_save_reg = if_id_q.ls_reg;
  assign load_save_imm = if_id_q.ls_imm;
  assign call_target   = if_id_q.call_tgt;
  assign pc_out        = if_id_q.pc;
  assign halted        = halted_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: vector table, directed corner sequences, randomized run vs. a queue model.
// Latency: n/a.
// Backpressure: memory model supports fixed latency or random ready.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_id_valid;
  logic [3:0]  cntrl_opcode, branch_cond, reg_rs, reg_rt_arith, arith_imm, load_save_reg;
  logic [7:0]  load_save_imm;
  logic [11:0] call_target;
  logic [15:0] pc_out;
  logic        halted;

  if_fetch_unit_if mif ();

  if_fetch_unit #(.RESET_PC(16'h0000), .HLT_OPCODE(4'hF)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (mif),
    .if_id_valid    (if_id_valid),
    .cntrl_opcode   (cntrl_opcode),
    .branch_cond    (branch_cond),
    .reg_rs         (reg_rs),
    .reg_rt_arith   (reg_rt_arith),
    .arith_imm      (arith_imm),
    .load_save_reg  (load_save_reg),
    .load_save_imm  (load_save_imm),
    .call_target    (call_target),
    .pc_out         (pc_out),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [15:0] ovr [int];
  int          lat = 1;
  logic        rnd_mode = 1'b0;
  logic        rnd_rdy = 1'b0;
  int          wcnt;

  // Default contents never carry opcode F
  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    if (ovr.exists(int'(a))) return ovr[int'(a)];
    return {1'b0, a[2:0], a[11:0] ^ 12'hA5C};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (mif.imem_req && !mif.imem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(negedge clk) begin
    mif.imem_ready <= mif.imem_req && (rnd_mode ? rnd_rdy : (wcnt >= lat - 1));
    mif.imem_rdata <= mem_fn(mif.imem_addr);
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic        stall;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [3:0]  opc;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] pco;
  } vec_t;

  vec_t tbl [0:8];

  // random-run model state
  logic [31:0] m_q [$];
  logic [15:0] m_pc, m_stale_addr, m_word, m_pco, addr;
  logic        m_req, m_valid, m_stale, rdy;
  logic [15:0] w;

  initial begin
    // zero-wait stream with a 3-cycle stall while 0xA0B1 returns
    tbl[0] = '{1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 16'h0000, 1'b0, 4'h0, 4'h0, 4'h0, 16'h0000};
    tbl[2] = '{1'b0, 1'b1, 16'h0001, 1'b1, 4'h1, 4'h3, 4'h4, 16'h0001};
    tbl[3] = '{1'b1, 1'b1, 16'h0002, 1'b1, 4'h5, 4'h7, 4'h8, 16'h0002};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'h5, 4'h7, 4'h8, 16'h0002};
    tbl[5] = '{1'b1, 1'b0, 16'h0000, 1'b1, 4'h5, 4'h7, 4'h8, 16'h0002};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'h5, 4'h7, 4'h8, 16'h0002};
    tbl[7] = '{1'b0, 1'b1, 16'h0003, 1'b1, 4'hA, 4'hB, 4'h1, 16'h0003};
    tbl[8] = '{1'b0, 1'b1, 16'h0004, 1'b1, 4'h2, 4'h6, 4'h8, 16'h0004};
    ovr[0] = 16'h1234;
    ovr[1] = 16'h5678;
    ovr[2] = 16'hA0B1;
    ovr[3] = 16'h2468;

    // reset state
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    #12;
    chk("rst_req", mif.imem_req, 0);
    chk("rst_addr", mif.imem_addr, 0);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_fields", {cntrl_opcode, branch_cond, reg_rs, reg_rt_arith, call_target}, 0);
    chk("rst_pcout", pc_out, 0);
    chk("rst_halted", halted, 0);

    // table
    lat = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("tbl%0d_req", i), mif.imem_req, tbl[i].exp_req);
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), mif.imem_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), if_id_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_opc", i), cntrl_opcode, tbl[i].opc);
      chk($sformatf("tbl%0d_rs", i), reg_rs, tbl[i].rs);
      chk($sformatf("tbl%0d_rt", i), reg_rt_arith, tbl[i].rt);
      chk($sformatf("tbl%0d_pcout", i), pc_out, tbl[i].pco);
      stall = tbl[i].stall;
      tick();
    end
    stall = 1'b0;

    // redirect during a 3-cycle-latency request
    lat = 3;
    do_reset();
    tick();
    chk("drn_req1", mif.imem_req, 1);
    chk("drn_addr1", mif.imem_addr, 16'h0000);
    tick();
    chk("drn_addr2", mif.imem_addr, 16'h0000);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    chk("drn_hold_req", mif.imem_req, 1);
    chk("drn_hold_addr", mif.imem_addr, 16'h0000);
    chk("drn_valid3", if_id_valid, 0);
    tick();
    chk("drn_new_addr", mif.imem_addr, 16'h0040);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drn_bubble%0d", i), if_id_valid, 0);
      tick();
    end
    chk("drn_valid_new", if_id_valid, 1);
    chk("drn_pcout", pc_out, 16'h0041);
    w = mem_fn(16'h0040);
    chk("drn_inst", {cntrl_opcode, branch_cond, reg_rs, reg_rt_arith}, w);

    // redirect + stall with skid full
    lat = 1;
    do_reset();
    tick();
    stall = 1'b1;
    tick();
    chk("sk_hold_req", mif.imem_req, 0);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    chk("sk_rd_valid", if_id_valid, 0);
    chk("sk_rd_req", mif.imem_req, 1);
    chk("sk_rd_addr", mif.imem_addr, 16'h0100);
    stall = 1'b0;
    tick();
    chk("sk_rd_valid2", if_id_valid, 1);
    chk("sk_rd_pcout", pc_out, 16'h0101);
    w = mem_fn(16'h0100);
    chk("sk_rd_inst", {cntrl_opcode, branch_cond, reg_rs, reg_rt_arith}, w);

    // HLT then redirect
    ovr[2] = 16'hF000;
    do_reset();
    tick();
    tick();
    tick();
    chk("hlt_pre", halted, 0);
    tick();
    chk("hlt_set", halted, 1);
    chk("hlt_opc", cntrl_opcode, 4'hF);
    chk("hlt_req", mif.imem_req, 0);
    tick();
    chk("hlt_req2", mif.imem_req, 0);
    chk("hlt_keep", halted, 1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    chk("hlt_clr", halted, 0);
    chk("hlt_resume_req", mif.imem_req, 1);
    chk("hlt_resume_addr", mif.imem_addr, 16'h0010);
    tick();
    chk("hlt_resume_pcout", pc_out, 16'h0011);

    // PC wrap at 0xFFFF
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", mif.imem_addr, 16'hFFFF);
    tick();
    chk("wrap_valid", if_id_valid, 1);
    chk("wrap_pcout", pc_out, 16'h0000);
    chk("wrap_next_addr", mif.imem_addr, 16'h0000);

    // reset during a pending request
    lat = 3;
    tick();
    chk("mrst_pending", mif.imem_req, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", mif.imem_req, 0);
    chk("mrst_addr", mif.imem_addr, 0);
    chk("mrst_valid", if_id_valid, 0);
    chk("mrst_fields", {cntrl_opcode, call_target, pc_out, halted}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("mrst_restart_req", mif.imem_req, 1);
    chk("mrst_restart_addr", mif.imem_addr, 16'h0000);

    // randomized run against a transaction-level model
    ovr.delete();
    rnd_mode = 1'b1;
    do_reset();
    tick();
    m_q.delete();
    m_pc = 16'h0000;
    m_req = 1'b1;
    m_valid = 1'b0;
    m_stale = 1'b0;
    m_stale_addr = 16'h0000;
    m_word = 16'h0000;
    m_pco = 16'h0000;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("rnd_req", mif.imem_req, m_req);
      if (m_req) chk("rnd_addr", mif.imem_addr, m_stale ? m_stale_addr : m_pc);
      chk("rnd_valid", if_id_valid, m_valid);
      chk("rnd_inst", {cntrl_opcode, branch_cond, reg_rs, reg_rt_arith}, m_word);
      chk("rnd_ls", {load_save_reg, load_save_imm}, m_word[11:0]);
      chk("rnd_call", {call_target, arith_imm}, {m_word[11:0], m_word[3:0]});
      chk("rnd_pcout", pc_out, m_pco);
      chk("rnd_halted", halted, 0);
      stall = ($urandom_range(99) < 30);
      redirect_valid = ($urandom_range(99) < 5);
      redirect_pc = 16'($urandom);
      rnd_rdy = ($urandom_range(99) < 60);
      rdy = m_req && rnd_rdy;
      addr = m_stale ? m_stale_addr : m_pc;
      if (redirect_valid) begin
        m_q.delete();
        m_valid = 1'b0;
        if (m_stale) begin
          if (rdy) m_stale = 1'b0;
        end else if (m_req && !rdy) begin
          m_stale = 1'b1;
          m_stale_addr = m_pc;
        end
        m_pc = redirect_pc;
      end else begin
        if (m_stale) begin
          if (rdy) m_stale = 1'b0;
        end else if (rdy) begin
          m_q.push_back({mem_fn(addr), m_pc + 16'd1});
          m_pc = m_pc + 16'd1;
        end
        if (!stall) begin
          if (m_q.size() > 0) begin
            {m_word, m_pco} = m_q.pop_front();
            m_valid = 1'b1;
          end else begin
            m_valid = 1'b0;
          end
        end
      end
      m_req = (m_q.size() == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; the producer end of the IF/ID pipeline interface that the decode stage consumes.
- Owns the PC and issues word requests to instruction memory over a req/ready handshake.
- Holds at most one returned word in a skid buffer while decode stalls.
- Splits each instruction into the IF/ID field bundle, and handles redirect, flush and halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HLT_OPCODE, 4'hF, opcode that stops fetching.

Ports:
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard unit: hold the IF/ID register
- redirect_valid  in  1  taken branch/call/ret from a later stage
- redirect_pc  in  16  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  16  word address; stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  single-cycle response strobe
- imem_rdata  in  16  instruction; valid when imem_ready=1
- if_id_valid  out  1  IF/ID holds a real instruction
- cntrl_opcode  out  4  inst[15:12]
- branch_cond  out  4  inst[11:8]
- reg_rs  out  4  inst[7:4]
- reg_rt_arith  out  4  inst[3:0]
- arith_imm  out  4  inst[3:0]
- load_save_reg  out  4  inst[11:8]
- load_save_imm  out  8  inst[7:0]
- call_target  out  12  inst[11:0]
- pc_out  out  16  address of the instruction + 1
- halted  out  1  an HLT has entered IF/ID

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0.
  - PC=RESET_PC; state IDLE; skid buffer empty.
  - A reset mid-transaction abandons the request; the memory ignores a dropped request.
- IDLE: lasts one cycle after rst_n rises, then goes to REQ.
- REQ:
  - imem_req=1, imem_addr=PC.
  - On imem_ready, the word is accepted and PC<=PC+1.
  - Accepted with stall=0: the word loads IF/ID and REQ continues. A zero-wait memory gives 1 instruction/cycle.
  - Accepted with stall=1: the word goes to the skid buffer and the state moves to HOLD.
- HOLD:
  - imem_req=0.
  - When stall falls, the skid buffer loads IF/ID, empties, and the state returns to REQ. The next request issues that same cycle.
- DRAIN:
  - Entered on redirect_valid while in REQ with no imem_ready that cycle.
  - imem_req stays 1 with the old address until imem_ready.
  - The returned data is discarded; then the state returns to REQ at the already-updated PC.
- HALT:
  - Entered when an accepted word has opcode=HLT_OPCODE.
  - No further requests issue.
  - halted=1 once that HLT is in IF/ID; it stays high until a redirect or reset.
- IF/ID update priority, per cycle:
  1. redirect_valid: if_id_valid<=0, skid cleared, PC<=redirect_pc, halted<=0, and the state leaves HALT/HOLD for REQ. Redirect overrides stall.
  2. stall: hold all IF/ID outputs.
  3. Skid full: load from skid.
  4. Word accepted this cycle: load from imem_rdata, if_id_valid<=1.
  5. Otherwise: if_id_valid<=0 (bubble). The fields keep their last values.
- Redirect coinciding with imem_ready in REQ: the returned word is dropped and the state goes directly to REQ at redirect_pc.
- Arithmetic: PC+1 wraps 16'hFFFF to 16'h0000. pc_out is the captured PC+1 with the same wrap.

Decomposition:
- Shared package wisc_pkg holds:
  - fetch_state_t {IDLE, REQ, HOLD, DRAIN, HALT}.
  - OP_HLT.
  - Instruction field bit-position localparams.
  - A packed if_id_t struct of the field bundle + pc + valid.
- One natural sub-module: fetch_skid_buf, a single-entry holding register with load/drain/clear and a full flag.

Test Plan:
- Zero-wait memory (imem_ready tied to imem_req), RESET_PC=0, memory returns words 0x1234, 0x5678 -> first imem_req 1 cycle after rst_n rise; IF/ID reports opcode 1, rs 3, rt 4, pc_out 1, then opcode 5, pc_out 2, on consecutive cycles.
- stall=1 for 3 cycles while a word 0xA0B1 returns -> imem_req drops; IF/ID holds the previous instruction; when stall falls, IF/ID shows 0xA0B1 fields and the next request is issued the same cycle at the correct PC.
- Memory with 3-cycle latency; redirect to 0x0040 in the second wait cycle -> imem_addr held at the old address until ready; that data is discarded; next request addr 0x0040; no valid instruction from the old stream.
- redirect_valid and stall both high with skid full -> if_id_valid=0, skid empty, PC=redirect target.
- Word 0xF000 fetched -> halted=1 next cycle and no further imem_req; then redirect to 0x0010 -> halted=0 and fetch resumes at 0x0010.
- PC=16'hFFFF fetch -> pc_out=0x0000, next imem_addr=0x0000; rst_n pulsed low during a pending request -> all outputs 0 immediately and PC=RESET_PC.
